// File: rtl/peripheral_bus_bridge.sv
// rtl/peripheral_bus_bridge.sv - Wishbone slave to internal peripheral-bus master bridge
//
// Purpose:
//   Accepts one Wishbone request at a time, latches it and presents it to the
//   peripheral bus as a registered write or read strobe. The strobe and all
//   latched fields are held while any peripheral asserts busy, so each write
//   strobe is committed exactly once. The OR-ed peripheral read data is
//   returned with a single-cycle ack.
//
// Optional feature (macro PERIPHERAL_BUS_TIMEOUT_EN):
//   Defined     - an 8-bit busy counter ends a stalled access after
//                 TIMEOUT_CYCLES busy cycles with a one-cycle wb_err_o.
//   Not defined - ACCESS waits on busy indefinitely, wb_err_o is tied low.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i        Wishbone cycle / strobe
//   wb_we_i, wb_sel_i         Wishbone write enable / byte selects
//   wb_adr_i, wb_data_i       Wishbone byte address / write data
//   wb_ack_o, wb_err_o        one-cycle acknowledge / error
//   wb_data_o                 read data, valid with wb_ack_o, otherwise 0
//   peripheralBus_we/oe       registered write / read strobes
//   peripheralBus_busy        a selected peripheral is stalling
//   peripheralBus_address     latched low ADDRESS_WIDTH address bits
//   peripheralBus_byteSelect  latched byte selects
//   peripheralBus_dataWrite   latched write data
//   peripheralBus_dataRead    OR of all peripheral read buses

module peripheral_bus_bridge #(
   parameter int ADDRESS_WIDTH  = 24,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   input  logic                     wb_we_i,
   input  logic [3:0]               wb_sel_i,
   input  logic [31:0]              wb_adr_i,
   input  logic [31:0]              wb_data_i,
   output logic                     wb_ack_o,
   output logic                     wb_err_o,
   output logic [31:0]              wb_data_o,
   output logic                     peripheralBus_we,
   output logic                     peripheralBus_oe,
   input  logic                     peripheralBus_busy,
   output logic [ADDRESS_WIDTH-1:0] peripheralBus_address,
   output logic [3:0]               peripheralBus_byteSelect,
   output logic [31:0]              peripheralBus_dataWrite,
   input  logic [31:0]              peripheralBus_dataRead
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t state;
   state_t stateNext;

   logic writeLatched;
   logic startAccess;
   logic finishAccess;
   logic abortAccess;
   logic timeoutAccess;
   logic timeoutHit;

   // Address bits above ADDRESS_WIDTH are deliberately dropped.
   generate
      if (ADDRESS_WIDTH < 32) begin : gUpperAddr
         logic unusedAddrHigh;
         assign unusedAddrHigh = ^wb_adr_i[31:ADDRESS_WIDTH];
      end
   endgenerate

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
   logic [7:0] busyCount;

   // Fires on the busy cycle that brings the count to TIMEOUT_CYCLES, so the
   // strobe is high for exactly TIMEOUT_CYCLES stalled cycles.
   assign timeoutHit = peripheralBus_busy &&
                       (({1'b0, busyCount} + 9'd1) >= 9'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busyCount <= 8'd0;
      end else if (startAccess) begin
         busyCount <= 8'd0;
      end else if (state == ACCESS && peripheralBus_busy) begin
         busyCount <= busyCount + 8'd1;
      end
   end
`else
   // The timeout limit only matters when the counter is built in.
   logic unusedTimeoutParam;
   assign unusedTimeoutParam = (TIMEOUT_CYCLES > 0);
   assign timeoutHit         = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext     = state;
      startAccess   = 1'b0;
      finishAccess  = 1'b0;
      abortAccess   = 1'b0;
      timeoutAccess = 1'b0;
      case (state)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               startAccess = 1'b1;
               stateNext   = ACCESS;
            end
         end
         ACCESS: begin
            // Abort wins: the master has gone, nobody is waiting for a reply.
            if (!wb_cyc_i) begin
               abortAccess = 1'b1;
               stateNext   = IDLE;
            end else if (!peripheralBus_busy) begin
               finishAccess = 1'b1;
               stateNext    = RESPOND;
            end else if (timeoutHit) begin
               timeoutAccess = 1'b1;
               stateNext     = IDLE;
            end
         end
         RESPOND: begin
            // A request still presented here is picked up in IDLE next cycle.
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack_o                 <= 1'b0;
         wb_err_o                 <= 1'b0;
         wb_data_o                <= 32'd0;
         peripheralBus_we         <= 1'b0;
         peripheralBus_oe         <= 1'b0;
         peripheralBus_address    <= '0;
         peripheralBus_byteSelect <= 4'd0;
         peripheralBus_dataWrite  <= 32'd0;
         writeLatched             <= 1'b0;
      end else begin
         wb_ack_o <= finishAccess;
         wb_err_o <= timeoutAccess;

         if (finishAccess && !writeLatched) begin
            wb_data_o <= peripheralBus_dataRead;
         end else begin
            wb_data_o <= 32'd0;
         end

         if (startAccess) begin
            peripheralBus_address    <= wb_adr_i[ADDRESS_WIDTH-1:0];
            peripheralBus_byteSelect <= wb_sel_i;
            peripheralBus_dataWrite  <= wb_data_i;
            writeLatched             <= wb_we_i;
            peripheralBus_we         <= wb_we_i;
            peripheralBus_oe         <= !wb_we_i;
         end else if (finishAccess || abortAccess || timeoutAccess) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
         end
      end
   end

endmodule
